// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: registered round-robin arbiter with a one-hot grant,
// a binary grant index and ack-based grant hold.
// Optional macro RR_ONEHOT_CHECK_EN builds a sticky grant-encoding checker
// that drives err; without it err is tied low.
module rr_onehot_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               err
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [IDX_W-1:0]   last_reg, last_next;

  // Search base: an ack'd grant becomes the new lowest-priority requester
  // in the same cycle, so back-to-back arbitration sees the updated pointer.
  logic [IDX_W-1:0]   search_base;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               served;

  assign served      = (state_reg == GRANT) && ack;
  assign search_base = served ? idx_reg : last_reg;

  // Round-robin search: scan base+1 .. base (wrapping); the nearest set
  // request wins, so iterate farthest-first and let closer hits overwrite.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int c;
      c = int'(search_base) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req[c]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(c);
      end
    end
  end

  // Decode the winning index into the one-hot grant pattern.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign win_onehot[gi] = win_valid && (win_idx == IDX_W'(gi));
    end
  endgenerate

  // Next-state logic: arbitrate from IDLE on any request, or from GRANT on ack.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    idx_next   = idx_reg;
    last_next  = last_reg;
    if (served) begin
      last_next = idx_reg;
    end
    if (((state_reg == IDLE) && (|req)) || served) begin
      if (win_valid) begin
        state_next = GRANT;
        gnt_next   = win_onehot;
        idx_next   = win_idx;
      end else begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    end
  end

  // State and output registers; reset restarts priority at requester 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      idx_reg   <= '0;
      last_reg  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      idx_reg   <= idx_next;
      last_reg  <= last_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = (state_reg == GRANT);
  assign gnt_idx   = idx_reg;

`ifdef RR_ONEHOT_CHECK_EN
  logic err_reg;
  logic enc_bad;

  // Flag a grant that is not one-hot while valid, or non-zero while idle.
  always_comb begin
    int ones;
    ones = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ones = ones + int'(gnt_reg[i]);
    end
    enc_bad = gnt_valid ? (ones != 1) : (ones != 0);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_reg <= 1'b0;
    end else if (enc_bad) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: scoreboard bench for rr_onehot_arbiter (NUM_REQ=4).
module tb_rr_onehot_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] req = '0;
  logic         ack = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic         err;

  rr_onehot_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .ack       (ack),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         valid;
    logic [W-1:0] idx;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   txn      = 0;

  // Reference model state: who holds the grant, and who was served last.
  bit   m_valid;
  int   m_idx;
  int   m_last;

  task automatic chk(input string name, input int actual, input int required);
    chk_cnt++;
    if (actual == required) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, actual, required);
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_idx   = 0;
    m_last  = N - 1;
  endtask

  // Advance the model by one clock with the given inputs, push expectation.
  task automatic model_step(input logic [N-1:0] r, input logic a);
    exp_t e;
    int   best, bestd, d;
    if ((!m_valid && r != 0) || (m_valid && a)) begin
      if (m_valid) m_last = m_idx;
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
        // distance after the last-served requester, 0 = highest priority
        d = (i - m_last - 1 + 2 * N) % N;
        if (r[i] && d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
      if (best >= 0) begin
        m_valid = 1;
        m_idx   = best;
      end else begin
        m_valid = 0;
      end
    end
    e.gnt   = m_valid ? N'(1 << m_idx) : '0;
    e.valid = m_valid;
    e.idx   = W'(m_idx);
    e.err   = 1'b0;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every registered output update against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      chk_cnt++;
      if (gnt === e.gnt && gnt_valid === e.valid && gnt_idx === e.idx && err === e.err) begin
        pass_cnt++;
        $display("txn %0d: req=%b ack=%b gnt=%b valid=%b idx=%0d err=%b ok",
                 txn, req, ack, gnt, gnt_valid, gnt_idx, err);
      end else begin
        $display("FAIL txn %0d: got gnt=%b valid=%b idx=%0d err=%b expected gnt=%b valid=%b idx=%0d err=%b",
                 txn, gnt, gnt_valid, gnt_idx, err, e.gnt, e.valid, e.idx, e.err);
      end
    end
  end

  // Drive one cycle of stimulus, then return just after the checked edge.
  task automatic step(input logic [N-1:0] r, input logic a);
    @(negedge clk);
    req = r;
    ack = a;
    model_step(r, a);
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset applied off-edge; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    resetn = 1'b0;
    req    = '0;
    ack    = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    chk("init_gnt", int'(gnt), 0);
    chk("init_valid", int'(gnt_valid), 0);
    chk("init_idx", int'(gnt_idx), 0);
    chk("init_err", int'(err), 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Single request, held grant, release to idle.
    step(4'b0100, 1'b0);
    chk("t1_gnt", int'(gnt), 4'b0100);
    chk("t1_idx", int'(gnt_idx), 2);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b0);
      chk("t1_hold", int'(gnt), 4'b0100);
    end
    step(4'b0000, 1'b1);
    chk("t1_idle_gnt", int'(gnt), 0);
    chk("t1_idle_valid", int'(gnt_valid), 0);
    chk("t1_idle_idx", int'(gnt_idx), 2);

    // Full rotation with no bubbles.
    do_reset();
    step(4'b1111, 1'b1);
    chk("t2_g0", int'(gnt), 4'b0001);
    step(4'b1111, 1'b1);
    chk("t2_g1", int'(gnt), 4'b0010);
    step(4'b1111, 1'b1);
    chk("t2_g2", int'(gnt), 4'b0100);
    step(4'b1111, 1'b1);
    chk("t2_g3", int'(gnt), 4'b1000);
    step(4'b1111, 1'b1);
    chk("t2_g4", int'(gnt), 4'b0001);

    // Sticky grant survives request drop.
    do_reset();
    step(4'b0011, 1'b0);
    chk("t3_gnt", int'(gnt), 4'b0001);
    for (int i = 0; i < 5; i++) step(4'b0010, 1'b0);
    chk("t3_sticky", int'(gnt), 4'b0001);
    step(4'b0010, 1'b1);
    chk("t3_next", int'(gnt), 4'b0010);

    // Wrap-around from requester 3 to 0.
    do_reset();
    step(4'b1000, 1'b0);
    chk("t4_g3", int'(gnt), 4'b1000);
    step(4'b1001, 1'b1);
    chk("t4_wrap_gnt", int'(gnt), 4'b0001);
    chk("t4_wrap_idx", int'(gnt_idx), 0);

    // Single requester with ack every cycle is granted every cycle.
    step(4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b1);
      chk("t6_single", int'(gnt), 4'b0100);
    end

    // Reset mid-grant, then priority restarts at requester 0.
    do_reset();
    step(4'b0100, 1'b0);
    chk("t5_gnt", int'(gnt), 4'b0100);
    do_reset();
    step(4'b1001, 1'b0);
    chk("t5_restart", int'(gnt), 4'b0001);

    // Random traffic against the reference model.
    for (int i = 0; i < 1000; i++) begin
      step(N'($urandom_range(0, (1 << N) - 1)), 1'($urandom_range(0, 1)));
    end
    chk("rand_err", int'(err), 0);

`ifdef RR_ONEHOT_CHECK_EN
    // Corrupt the grant register and expect the sticky error.
    @(negedge clk);
    req = '0;
    ack = 1'b0;
    force dut.gnt_reg = 4'b0110;
    @(posedge clk);
    #1;
    release dut.gnt_reg;
    @(posedge clk);
    #1;
    chk("chk_err_set", int'(err), 1);
    @(posedge clk);
    #1;
    chk("chk_err_sticky", int'(err), 1);
    do_reset();
    chk("chk_err_clear", int'(err), 0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Registered round-robin arbiter.
- Issues a one-hot grant vector to NUM_REQ requesters.
- Holds each grant until the consumer acknowledges it.
- Sits directly upstream of the team's one-hot detector, which consumes gnt as its din to flag illegal grant encodings. Also drives a binary grant index for downstream muxing.

Parameters:
- NUM_REQ, 8, number of requesters; legal range 2..32.
- IDX_W, $clog2(NUM_REQ), width of gnt_idx. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- req  input  NUM_REQ  request vector; bit i = requester i wants service
- ack  input  1  consumer has used the current grant; meaningful only while gnt_valid=1
- gnt  output  NUM_REQ  registered one-hot grant; all zeros when no grant is active
- gnt_valid  output  1  a grant is active
- gnt_idx  output  IDX_W  binary index of the set gnt bit; holds its last value when gnt_valid=0
- err  output  1  sticky encoding-error flag (see Optional Feature)

Behaviour:
- Reset (resetn low, asynchronous, takes effect immediately):
  - gnt=0, gnt_valid=0, gnt_idx=0, err=0.
  - State=IDLE.
  - last_idx=NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset mid-grant drops the grant with no ack required.
- State machine, two states:
  - IDLE: gnt_valid=0.
  - GRANT: gnt_valid=1; gnt and gnt_idx stable.
- Arbitration event: occurs in a cycle where (state==IDLE and |req) or (state==GRANT and ack).
  - Search order: (last_idx+1) mod NUM_REQ, then upward with wrap-around, ending at last_idx.
  - The first set req bit wins.
  - All outputs update at the next rising edge.
- IDLE -> GRANT: |req in cycle t gives gnt_valid=1 in cycle t+1. Latency 1 clock.
- GRANT with ack=0:
  - gnt, gnt_idx and gnt_valid hold.
  - The grant is sticky: deasserting req of the granted requester does not revoke it.
- GRANT with ack=1:
  - last_idx <= current gnt_idx.
  - If req is non-zero in the same cycle, the new winner is granted next cycle. This is back-to-back, with no idle bubble.
  - The just-served requester is included in the search at lowest priority.
  - If req is zero: go to IDLE, gnt<=0, gnt_valid<=0.
- ack while in IDLE is ignored.
- Single requester continuously asserting with ack every cycle receives a grant every cycle.
- Invariant: gnt_valid==(gnt!=0) and gnt is exactly one-hot whenever gnt_valid=1.
- Fairness: each continuously asserting requester is granted at least once every NUM_REQ grants.

Optional Feature:
- Macro: RR_ONEHOT_CHECK_EN.
- Defined:
  - Internal checker counts set bits of gnt each cycle.
  - err is set on the clock edge after either (gnt_valid=1 and popcount(gnt)!=1) or (gnt_valid=0 and gnt!=0).
  - err is sticky until resetn.
- Undefined: err is tied to 0 and no checker logic is built.
- Functional grant behaviour is identical in both builds.

Test Plan (NUM_REQ=4):
- Reset release, req=4'b0100 held for 1 cycle. Next cycle: gnt=4'b0100, gnt_idx=2, gnt_valid=1. Hold for 3 cycles with ack=0; outputs unchanged. Then ack=1 and req=0: next cycle gnt=0, gnt_valid=0.
- req=4'b1111 constant, ack=1 every cycle. Expected grant sequence 0001, 0010, 0100, 1000, 0001, with no bubbles.
- Sticky grant: req=4'b0011 gives gnt=0001. Drop req to 4'b0010 with ack=0 for 5 cycles; gnt stays 0001. Pulse ack; next cycle gnt=0010.
- Wrap-around: after a grant to idx 3 is acked, req=4'b1001 gives next gnt=0001, gnt_idx=0.
- Reset mid-grant: while gnt=0100, pull resetn low off-edge. gnt=0 and gnt_valid=0 immediately, with no clock needed. Release resetn with req=4'b1001; gnt=0001 (priority restarted at 0).
- With RR_ONEHOT_CHECK_EN, run 1000 cycles of random req/ack: err stays 0. Force gnt=4'b0110 for one cycle: err=1 next cycle and stays 1 until reset. Without the macro, err is always 0.
